// File: rtl/ibuf_rd_sched.sv
// ibuf_rd_sched: walks the input-buffer banks, issuing a read-address reset then a ready-paced row burst per bank
module ibuf_rd_sched #(
  parameter int REGNUM_W = 4,
  parameter int ROW_W = 8
) (
  input  logic                SYS_CLK,
  input  logic                SYS_RST,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [REGNUM_W-1:0] cfg_last_bank_i,
  input  logic [ROW_W-1:0]    cfg_last_row_i,
  input  logic                ready_i,
  output logic                raddr_rst_o,
  output logic                raddr_vld_o,
  output logic [REGNUM_W-1:0] ctrl_regnum_sel_o,
  output logic [ROW_W-1:0]    row_idx_o,
  output logic                busy_o,
  output logic                done_o
);
  typedef enum logic [2:0] {IDLE, RST, READ, GAP, DONE} state_t;
  state_t state;
  logic [REGNUM_W-1:0] bank, last_bank;
  logic [ROW_W-1:0] row, last_row;
  logic last_issued, last_bank_hit;
  // terminal compare uses the issued index, so the row counter may wrap harmlessly afterwards
  assign last_issued = raddr_vld_o && (row_idx_o == last_row);
  assign last_bank_hit = bank == last_bank;
  always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
    if (SYS_RST) begin
      state <= IDLE;
      bank <= '0;
      last_bank <= '0;
      row <= '0;
      last_row <= '0;
      raddr_rst_o <= 1'b0;
      raddr_vld_o <= 1'b0;
      ctrl_regnum_sel_o <= '0;
      row_idx_o <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      raddr_rst_o <= 1'b0;
      raddr_vld_o <= 1'b0;
      done_o <= 1'b0;
      if (abort_i && state != IDLE) begin
        state <= IDLE;
        busy_o <= 1'b0;
        bank <= '0;
        row <= '0;
      end else begin
        case (state)
          IDLE: if (start_i && !abort_i) begin
            last_bank <= cfg_last_bank_i;
            last_row <= cfg_last_row_i;
            bank <= '0;
            row <= '0;
            ctrl_regnum_sel_o <= '0;
            raddr_rst_o <= 1'b1;
            busy_o <= 1'b1;
            state <= RST;
          end
          // the RST cycle already samples ready_i, so row 0 can follow it directly
          RST, READ: begin
            state <= last_issued ? (last_bank_hit ? DONE : GAP) : READ;
            done_o <= last_issued && last_bank_hit;
            if (!last_issued && ready_i) begin
              raddr_vld_o <= 1'b1;
              row_idx_o <= row;
              row <= row + 1'b1;
            end
          end
          GAP: begin
            bank <= bank + 1'b1;
            ctrl_regnum_sel_o <= bank + 1'b1;
            row <= '0;
            raddr_rst_o <= 1'b1;
            state <= RST;
          end
          DONE: begin
            busy_o <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ibuf_rd_sched.sv
// tb_ibuf_rd_sched: directed and randomized runs against a transaction-list model of the bank walk
module tb_ibuf_rd_sched;
  localparam int RW = 4;
  localparam int WW = 8;
  logic SYS_CLK = 1'b0;
  logic SYS_RST = 1'b1;
  logic start_i = 1'b0;
  logic abort_i = 1'b0;
  logic ready_i = 1'b0;
  logic [RW-1:0] cfg_last_bank_i = '0;
  logic [WW-1:0] cfg_last_row_i = '0;
  logic raddr_rst_o, raddr_vld_o, busy_o, done_o;
  logic [RW-1:0] ctrl_regnum_sel_o;
  logic [WW-1:0] row_idx_o;
  int checks = 0;
  int errors = 0;
  // kind: 0 bank reset, 1 row read, 2 gap, 3 done
  typedef struct {int kind; int sel; int row;} item_t;
  item_t q[$];
  logic e_rst = 1'b0, e_vld = 1'b0, e_busy = 1'b0, e_done = 1'b0;
  logic [RW-1:0] e_sel = '0;
  logic [WW-1:0] e_row = '0;
  int dt;

  ibuf_rd_sched #(.REGNUM_W(RW), .ROW_W(WW)) dut (
    .SYS_CLK(SYS_CLK), .SYS_RST(SYS_RST), .start_i(start_i), .abort_i(abort_i),
    .cfg_last_bank_i(cfg_last_bank_i), .cfg_last_row_i(cfg_last_row_i), .ready_i(ready_i),
    .raddr_rst_o(raddr_rst_o), .raddr_vld_o(raddr_vld_o), .ctrl_regnum_sel_o(ctrl_regnum_sel_o),
    .row_idx_o(row_idx_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs();
    chk("raddr_rst", 32'(raddr_rst_o), 32'(e_rst));
    chk("raddr_vld", 32'(raddr_vld_o), 32'(e_vld));
    chk("busy", 32'(busy_o), 32'(e_busy));
    chk("done", 32'(done_o), 32'(e_done));
    chk("regnum_sel", 32'(ctrl_regnum_sel_o), 32'(e_sel));
    chk("row_idx", 32'(row_idx_o), 32'(e_row));
  endtask

  task automatic build();
    q.delete();
    for (int b = 0; b <= int'(cfg_last_bank_i); b++) begin
      q.push_back('{0, b, 0});
      for (int r = 0; r <= int'(cfg_last_row_i); r++) q.push_back('{1, b, r});
      if (b == int'(cfg_last_bank_i)) q.push_back('{3, b, 0});
      else q.push_back('{2, b, 0});
    end
  endtask

  // one clock: model reacts to the inputs of the cycle that is ending, then outputs are checked
  task automatic step();
    logic r, a, s;
    item_t h;
    r = ready_i;
    a = abort_i;
    s = start_i;
    if (a && e_busy) q.delete();
    else if (s && !a && !e_busy) build();
    @(posedge SYS_CLK);
    #1;
    e_rst = 1'b0;
    e_vld = 1'b0;
    e_done = 1'b0;
    e_busy = q.size() != 0;
    if (e_busy) begin
      h = q[0];
      if (h.kind == 0) begin
        e_rst = 1'b1;
        e_sel = RW'(h.sel);
        void'(q.pop_front());
      end else if (h.kind == 1) begin
        if (r) begin
          e_vld = 1'b1;
          e_row = WW'(h.row);
          void'(q.pop_front());
        end
      end else begin
        e_done = h.kind == 3;
        void'(q.pop_front());
      end
    end
    chk_outputs();
  endtask

  // mode 1: ready high, 2: random ready, 3: ready low in cycles 2-3,
  // 4: start + cfg change at cycle 3, 5: abort at cycle 8
  task automatic run_seq(input int lb, input int lr, input int mode, output int done_t);
    int t;
    cfg_last_bank_i = RW'(lb);
    cfg_last_row_i = WW'(lr);
    start_i = 1'b1;
    ready_i = 1'b1;
    done_t = -1;
    step();
    start_i = 1'b0;
    t = 1;
    while (e_busy && t < 6000) begin
      ready_i = (mode == 2) ? ($urandom_range(0, 3) != 0) : !(mode == 3 && (t == 2 || t == 3));
      start_i = mode == 4 && t == 3;
      if (mode == 4 && t == 3) begin
        cfg_last_bank_i = RW'($urandom);
        cfg_last_row_i = WW'($urandom);
      end
      abort_i = mode == 5 && t == 8;
      step();
      t++;
      if (e_done) done_t = t;
    end
    abort_i = 1'b0;
    start_i = 1'b0;
    chk("seq_within_budget", 32'(t < 6000), 32'd1);
  endtask

  initial begin
    #2;
    chk_outputs();
    #10 SYS_RST = 1'b0;
    step();
    step();
    run_seq(1, 2, 1, dt);
    chk("nominal_done_t", 32'(dt), 32'd10);
    step();
    run_seq(1, 2, 3, dt);
    chk("backpressure_done_t", 32'(dt), 32'd12);
    run_seq(1, 2, 5, dt);
    chk("abort_no_done", 32'(dt), 32'hffffffff);
    run_seq(1, 2, 1, dt);
    chk("after_abort_done_t", 32'(dt), 32'd10);
    run_seq(0, 0, 1, dt);
    chk("minimal_done_t", 32'(dt), 32'd3);
    run_seq(1, 2, 4, dt);
    chk("start_while_busy_done_t", 32'(dt), 32'd10);
    // asynchronous reset in the middle of a bank read
    cfg_last_bank_i = 4'd2;
    cfg_last_row_i = 8'd5;
    start_i = 1'b1;
    ready_i = 1'b1;
    step();
    start_i = 1'b0;
    repeat (4) step();
    #2 SYS_RST = 1'b1;
    #1;
    q.delete();
    e_rst = 1'b0;
    e_vld = 1'b0;
    e_busy = 1'b0;
    e_done = 1'b0;
    e_sel = '0;
    e_row = '0;
    chk_outputs();
    #1 SYS_RST = 1'b0;
    repeat (3) step();
    run_seq(0, 3, 1, dt);
    chk("post_reset_done_t", 32'(dt), 32'd6);
    run_seq(15, 255, 1, dt);
    chk("max_cfg_done_t", 32'(dt), 32'd4128);
    for (int i = 0; i < 20; i++) begin
      int lb, lr;
      lb = $urandom_range(0, 3);
      lr = $urandom_range(0, 7);
      run_seq(lb, lr, (i % 2 == 0) ? 2 : 1, dt);
      if (i % 2 == 1) chk("rand_done_t", 32'(dt), 32'((lb + 1) * (lr + 2) + lb + 1));
      repeat ($urandom_range(0, 2)) step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
